// File: rtl/data_cache_ctrl.sv
// ---------------------------------------------------------------------------
// data_cache_ctrl
//   Direct-mapped, one-word-per-line, write-through / no-write-allocate data
//   cache controller. The data storage lives outside this block as four
//   byte-lane arrays; this block owns the tag and valid arrays and the FSM.
//
// Ports
//   clk_i, rst_i                 clock, synchronous active-high reset
//   cpu_req_i/we_i/addr_i/wdata_i/be_i
//                                CPU request, sampled only in IDLE
//   cpu_busy_o, cpu_ready_o, cpu_rdata_o
//                                CPU status / one-cycle completion + load data
//   mem_req_o/we_o/addr_o/wdata_o/be_o, mem_ack_i, mem_rdata_i
//                                backing-memory request/ack port
//   lane_addr_o/wdata_o/we_o, lane_rdata_i
//                                byte-lane storage arrays (async read)
//   inv_i                        invalidate all lines (honoured in IDLE only)
// ---------------------------------------------------------------------------
module data_cache_ctrl #(
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cpu_req_i,
    input  logic                  cpu_we_i,
    input  logic [31:0]           cpu_addr_i,
    input  logic [31:0]           cpu_wdata_i,
    input  logic [3:0]            cpu_be_i,
    output logic                  cpu_busy_o,
    output logic                  cpu_ready_o,
    output logic [31:0]           cpu_rdata_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [31:0]           mem_addr_o,
    output logic [31:0]           mem_wdata_o,
    output logic [3:0]            mem_be_o,
    input  logic                  mem_ack_i,
    input  logic [31:0]           mem_rdata_i,
    output logic [ADDR_WIDTH-1:0] lane_addr_o,
    output logic [31:0]           lane_wdata_o,
    output logic [3:0]            lane_we_o,
    input  logic [31:0]           lane_rdata_i,
    input  logic                  inv_i
);
    localparam int NUM_LINES = 1 << ADDR_WIDTH;
    localparam int TAG_W     = 30 - ADDR_WIDTH;

    typedef enum logic [2:0] {IDLE, COMPARE, FILL, WRITE_MEM, RESPOND} state_e;

    state_e                 state_q, state_d;
    logic                   we_q, we_d;
    logic [31:2]            addr_q, addr_d;     // word address; byte offset is never needed
    logic [31:0]            wdata_q, wdata_d;
    logic [3:0]             be_q, be_d;
    logic [31:0]            fill_q, fill_d;
    logic [NUM_LINES-1:0]   valid_q, valid_d;
    logic [TAG_W-1:0]       tag_q [NUM_LINES];
    logic [TAG_W-1:0]       tag_d [NUM_LINES];

    logic [ADDR_WIDTH-1:0]  idx;
    logic [TAG_W-1:0]       tag;
    logic                   hit;

    logic                   unused_addr_lsb;
    assign unused_addr_lsb = ^cpu_addr_i[1:0];

    assign idx = addr_q[ADDR_WIDTH+1:2];
    assign tag = addr_q[31:ADDR_WIDTH+2];
    assign hit = valid_q[idx] && (tag_q[idx] == tag);

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        fill_d       = fill_q;
        valid_d      = valid_q;
        tag_d        = tag_q;

        cpu_busy_o   = (state_q != IDLE);
        cpu_ready_o  = 1'b0;
        cpu_rdata_o  = '0;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        mem_addr_o   = '0;
        mem_wdata_o  = '0;
        mem_be_o     = '0;
        lane_addr_o  = idx;
        lane_wdata_o = '0;
        lane_we_o    = '0;

        case (state_q)
            IDLE: begin
                if (inv_i) begin
                    valid_d = '0;
                end else if (cpu_req_i) begin
                    we_d    = cpu_we_i;
                    addr_d  = cpu_addr_i[31:2];
                    wdata_d = cpu_wdata_i;
                    be_d    = cpu_be_i;
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                if (we_q) begin
                    // Write-through: update the line only if present, always go to memory.
                    if (hit) begin
                        lane_we_o    = be_q;
                        lane_wdata_o = wdata_q;
                    end
                    state_d = WRITE_MEM;
                end else if (hit) begin
                    cpu_ready_o = 1'b1;
                    cpu_rdata_o = lane_rdata_i;
                    state_d     = IDLE;
                end else begin
                    state_d = FILL;
                end
            end
            FILL: begin
                mem_req_o  = 1'b1;
                mem_addr_o = {addr_q, 2'b00};
                if (mem_ack_i) begin
                    lane_we_o    = 4'b1111;
                    lane_wdata_o = mem_rdata_i;
                    tag_d[idx]   = tag;
                    valid_d[idx] = 1'b1;
                    fill_d       = mem_rdata_i;
                    state_d      = RESPOND;
                end
            end
            WRITE_MEM: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = {addr_q, 2'b00};
                mem_wdata_o = wdata_q;
                mem_be_o    = be_q;
                if (mem_ack_i) state_d = RESPOND;
            end
            RESPOND: begin
                cpu_ready_o = 1'b1;
                cpu_rdata_o = we_q ? 32'h0 : fill_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Reset overrides everything, including outputs of whatever state the
        // FSM happens to be in during the reset cycle.
        if (rst_i) begin
            state_d      = IDLE;
            valid_d      = '0;
            cpu_busy_o   = 1'b0;
            cpu_ready_o  = 1'b0;
            cpu_rdata_o  = '0;
            mem_req_o    = 1'b0;
            mem_we_o     = 1'b0;
            mem_addr_o   = '0;
            mem_wdata_o  = '0;
            mem_be_o     = '0;
            lane_wdata_o = '0;
            lane_we_o    = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            fill_q  <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            fill_q  <= fill_d;
            valid_q <= valid_d;
        end
    end

    // Tags are qualified by valid bits, so they carry no reset.
    always_ff @(posedge clk_i) begin
        tag_q <= tag_d;
    end

endmodule

// File: tb/tb_data_cache_ctrl.sv
module tb_data_cache_ctrl;
    localparam int AW   = 3;
    localparam int NL   = 1 << AW;
    localparam int TAGW = 30 - AW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_i = 1'b1;
    logic          cpu_req_i = 1'b0, cpu_we_i = 1'b0, inv_i = 1'b0;
    logic [31:0]   cpu_addr_i = '0, cpu_wdata_i = '0;
    logic [3:0]    cpu_be_i = '0;
    logic          cpu_busy_o, cpu_ready_o;
    logic [31:0]   cpu_rdata_o;
    logic          mem_req_o, mem_we_o;
    logic [31:0]   mem_addr_o, mem_wdata_o;
    logic [3:0]    mem_be_o;
    logic          mem_ack_i = 1'b0;
    logic [31:0]   mem_rdata_i = '0;
    logic [AW-1:0] lane_addr_o;
    logic [31:0]   lane_wdata_o, lane_rdata_i;
    logic [3:0]    lane_we_o;

    data_cache_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
        .cpu_wdata_i(cpu_wdata_i), .cpu_be_i(cpu_be_i),
        .cpu_busy_o(cpu_busy_o), .cpu_ready_o(cpu_ready_o), .cpu_rdata_o(cpu_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .lane_addr_o(lane_addr_o), .lane_wdata_o(lane_wdata_o),
        .lane_we_o(lane_we_o), .lane_rdata_i(lane_rdata_i),
        .inv_i(inv_i)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- byte-lane storage (async read) ----------------
    logic [7:0] lane_mem [4][NL];
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++)
            if (lane_we_o[k]) lane_mem[k][lane_addr_o] <= lane_wdata_o[8*k +: 8];
    end
    always_comb begin
        lane_rdata_i = {lane_mem[3][lane_addr_o], lane_mem[2][lane_addr_o],
                        lane_mem[1][lane_addr_o], lane_mem[0][lane_addr_o]};
    end

    // ---------------- memories: environment and reference ----------------
    logic [31:0] tb_mem  [bit [29:0]];
    logic [31:0] ref_mem [bit [29:0]];

    function automatic logic [31:0] init_word(input bit [29:0] w);
        return {w[15:0], ~w[15:0]} ^ 32'h3C5A_96E1;
    endfunction
    function automatic logic [31:0] rd_tb(input bit [29:0] w);
        return tb_mem.exists(w) ? tb_mem[w] : init_word(w);
    endfunction
    function automatic logic [31:0] rd_ref(input bit [29:0] w);
        return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
    endfunction
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = nw[8*k +: 8];
        return r;
    endfunction

    // ---------------- memory responder ----------------
    int dly = -1;
    int fixed_dly = -1;
    always @(posedge clk) begin
        #1;
        if (rst_i || !mem_req_o) begin
            mem_ack_i   = 1'($urandom_range(0, 1));   // must be ignored
            mem_rdata_i = $urandom;
            dly = -1;
        end else begin
            if (dly < 0) dly = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 3));
            if (dly == 0) begin
                mem_ack_i = 1'b1;
                dly = -1;
                if (mem_we_o)
                    tb_mem[mem_addr_o[31:2]] = merge(rd_tb(mem_addr_o[31:2]), mem_wdata_o, mem_be_o);
                else
                    mem_rdata_i = rd_tb(mem_addr_o[31:2]);
            end else begin
                mem_ack_i   = 1'b0;
                mem_rdata_i = $urandom;
                dly--;
            end
        end
    end

    // ---------------- reference cache state + scoreboard ----------------
    bit             ref_valid [NL];
    logic [TAGW-1:0] ref_tag  [NL];

    typedef struct {
        logic        we;
        logic        hit;
        logic        fill;
        logic [31:0] rdata;
        logic [31:0] maddr;
        logic [3:0]  mbe;
        logic [3:0]  lwe;
        int          lcnt;
    } exp_t;
    exp_t sbq[$];

    // ---------------- monitor ----------------
    int          n_busy = 0, n_fill = 0, n_mwr = 0, n_lw = 0;
    logic [3:0]  s_lwe = '0, s_mbe = '0;
    logic [31:0] s_maddr = '0;

    always @(negedge clk) begin
        if (rst_i) begin
            n_busy = 0; n_fill = 0; n_mwr = 0; n_lw = 0; s_lwe = '0;
        end else begin
            if (cpu_busy_o) n_busy++;
            if (mem_req_o && mem_ack_i) begin
                if (mem_we_o) begin n_mwr++; s_mbe = mem_be_o; end
                else n_fill++;
                s_maddr = mem_addr_o;
            end
            if (lane_we_o != 4'b0) begin n_lw++; s_lwe |= lane_we_o; end
            if (cpu_ready_o) begin
                if (sbq.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_ready: got ready with empty scoreboard, expected none");
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("rdata", cpu_rdata_o, e.rdata);
                    check("fill_count", 32'(n_fill), 32'(e.fill));
                    check("memwr_count", 32'(n_mwr), 32'(e.we));
                    if (e.fill || e.we) check("mem_addr", s_maddr, e.maddr);
                    if (e.we) check("mem_be", 32'(s_mbe), 32'(e.mbe));
                    check("lane_we", 32'(s_lwe), 32'(e.lwe));
                    check("lane_we_cycles", 32'(n_lw), 32'(e.lcnt));
                    if (!e.we) check("hit_1cycle", 32'(n_busy == 1), 32'(e.hit));
                end
                n_busy = 0; n_fill = 0; n_mwr = 0; n_lw = 0; s_lwe = '0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_idle();
        int n = 0;
        while (cpu_busy_o && n < 60) begin @(posedge clk); #2; n++; end
        check("idle_timeout", 32'(cpu_busy_o), 32'(0));
    endtask

    task automatic issue(input logic we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] be);
        exp_t e;
        int   idx;
        logic [TAGW-1:0] tg;
        bit [29:0] w;
        bit   h;
        w   = addr[31:2];
        idx = int'(addr[AW+1:2]);
        tg  = addr[31:AW+2];
        h   = ref_valid[idx] && (ref_tag[idx] == tg);
        e.we = we; e.hit = h; e.maddr = {addr[31:2], 2'b00};
        if (!we) begin
            e.rdata = rd_ref(w); e.fill = !h; e.mbe = '0;
            e.lwe = h ? 4'h0 : 4'hF; e.lcnt = h ? 0 : 1;
            if (!h) begin ref_valid[idx] = 1'b1; ref_tag[idx] = tg; end
        end else begin
            e.rdata = '0; e.fill = 1'b0; e.mbe = be;
            e.lwe = h ? be : 4'h0; e.lcnt = (h && be != 4'h0) ? 1 : 0;
            ref_mem[w] = merge(rd_ref(w), wd, be);
        end
        sbq.push_back(e);
        cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_wdata_i = wd; cpu_be_i = be;
        @(posedge clk); #2;
        cpu_req_i = 1'b0; cpu_we_i = 1'($urandom); cpu_addr_i = $urandom;
        cpu_wdata_i = $urandom; cpu_be_i = 4'($urandom);
        wait_idle();
    endtask

    task automatic clear_ref_valid();
        for (int i = 0; i < NL; i++) ref_valid[i] = 1'b0;
    endtask

    task automatic do_inv(input logic with_req, input logic [31:0] addr);
        inv_i = 1'b1; cpu_req_i = with_req; cpu_we_i = 1'b0; cpu_addr_i = addr;
        @(posedge clk); #2;
        check("inv_not_accepted", 32'(cpu_busy_o), 32'(0));
        inv_i = 1'b0; cpu_req_i = 1'b0;
        clear_ref_valid();
    endtask

    task automatic rst_mid_fill(input logic [31:0] addr);
        int n = 0;
        fixed_dly = 30;
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = addr;
        @(posedge clk); #2;
        cpu_req_i = 1'b0;
        while (!mem_req_o && n < 10) begin @(posedge clk); #2; n++; end
        check("fill_entered", 32'(mem_req_o), 32'(1));
        rst_i = 1'b1;
        @(negedge clk);
        check("rst_fill_mem_req", 32'(mem_req_o), 32'(0));
        check("rst_fill_busy", 32'(cpu_busy_o), 32'(0));
        check("rst_fill_lane_we", 32'(lane_we_o), 32'(0));
        @(posedge clk); #2;
        rst_i = 1'b0;
        @(negedge clk);
        check("post_rst_mem_req", 32'(mem_req_o), 32'(0));
        check("post_rst_busy", 32'(cpu_busy_o), 32'(0));
        fixed_dly = -1;
        clear_ref_valid();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        clear_ref_valid();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(cpu_busy_o), 32'(0));
        check("rst_ready", 32'(cpu_ready_o), 32'(0));
        check("rst_rdata", cpu_rdata_o, 32'h0);
        check("rst_mem_req", 32'(mem_req_o), 32'(0));
        check("rst_mem_we", 32'(mem_we_o), 32'(0));
        check("rst_mem_addr", mem_addr_o, 32'h0);
        check("rst_mem_wdata", mem_wdata_o, 32'h0);
        check("rst_mem_be", 32'(mem_be_o), 32'(0));
        check("rst_lane_we", 32'(lane_we_o), 32'(0));
        @(posedge clk); #2;
        rst_i = 1'b0;

        // Cold load with a fixed 3-cycle ack delay, then a hit.
        tb_mem[30'h9]  = 32'hDEADBEEF;
        ref_mem[30'h9] = 32'hDEADBEEF;
        fixed_dly = 3;
        issue(1'b0, 32'h24, 32'h0, 4'h0);
        fixed_dly = -1;
        issue(1'b0, 32'h24, 32'h0, 4'hF);
        // Partial store on a hit, then read back the merged word.
        issue(1'b1, 32'h24, 32'h0000AB00, 4'b0010);
        issue(1'b0, 32'h24, 32'h0, 4'h0);
        // Store miss: no allocate.
        issue(1'b1, 32'h48, 32'h12345678, 4'hF);
        issue(1'b0, 32'h48, 32'h0, 4'h0);
        // Conflict on index 1.
        issue(1'b0, 32'h24, 32'h0, 4'h0);
        issue(1'b0, 32'h44, 32'h0, 4'h0);
        issue(1'b0, 32'h24, 32'h0, 4'h0);
        // Store hit with no byte enables.
        issue(1'b1, 32'h24, 32'hFFFF_FFFF, 4'h0);
        issue(1'b0, 32'h25, 32'h0, 4'h0);
        // Reset during a fill.
        rst_mid_fill(32'h64);
        issue(1'b0, 32'h64, 32'h0, 4'h0);
        issue(1'b0, 32'h64, 32'h0, 4'h0);
        // Invalidate together with a request.
        issue(1'b0, 32'h48, 32'h0, 4'h0);
        do_inv(1'b1, 32'h24);
        issue(1'b0, 32'h24, 32'h0, 4'h0);
        issue(1'b0, 32'h48, 32'h0, 4'h0);
        issue(1'b0, 32'h64, 32'h0, 4'h0);

        // Randomized traffic over a small address pool to force hits and conflicts.
        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(0, 19) == 0) begin
                do_inv(1'($urandom_range(0, 1)), $urandom);
            end else begin
                logic [31:0] a;
                a = {25'h0, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3))};
                issue(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom));
            end
        end

        repeat (5) @(posedge clk);
        check("scoreboard_drained", 32'(sbq.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/data_cache_ctrl.md
DATA_CACHE_CTRL -- requirements
Module: data_cache_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 3, giving the cache index width; the cache holds 2**ADDR_WIDTH one-word lines.
REQ-002 SHALL have clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have rst_i, input, 1, synchronous active-high reset.
REQ-004 SHALL have cpu_req_i, input, 1, request valid; sampled only while cpu_busy_o=0.
REQ-005 SHALL have cpu_we_i, input, 1: 1=store, 0=load.
REQ-006 SHALL have cpu_addr_i, input, 32, byte address: bits [1:0] offset, [ADDR_WIDTH+1:2] index, [31:ADDR_WIDTH+2] tag.
REQ-007 SHALL have cpu_wdata_i, input, 32, store data, lane-aligned.
REQ-008 SHALL have cpu_be_i, input, 4, store byte enables; bit k selects byte [8k+7:8k].
REQ-009 SHALL have cpu_busy_o, output, 1, high whenever the FSM is not in IDLE.
REQ-010 SHALL have cpu_ready_o, output, 1, one-cycle completion pulse.
REQ-011 SHALL have cpu_rdata_o, output, 32, load data; valid only while cpu_ready_o=1.
REQ-012 SHALL have mem_req_o, mem_we_o (1), mem_addr_o (32, word-aligned, bits [1:0]=0), mem_wdata_o (32), mem_be_o (4) as outputs, and mem_ack_i (1), mem_rdata_i (32) as inputs, forming the backing-memory port.
REQ-013 SHALL have lane_addr_o (ADDR_WIDTH), lane_wdata_o (32) and lane_we_o (4) as outputs, and lane_rdata_i (32) as input, driving four 8-bit byte-lane storage arrays; lane k uses bits [8k+7:8k] and reads asynchronously.
REQ-014 SHALL have inv_i, input, 1, invalidate-all request.

Function
REQ-015 SHALL implement the FSM states IDLE, COMPARE, FILL, WRITE_MEM and RESPOND, plus internal tag and valid arrays of 2**ADDR_WIDTH entries.
REQ-016 IDLE: if inv_i=1, SHALL clear all valid bits that cycle and ignore cpu_req_i; otherwise, if cpu_req_i=1, SHALL latch we, addr, wdata and be, and move to COMPARE.
REQ-017 In any state other than IDLE, inv_i SHALL be ignored.
REQ-018 lane_addr_o SHALL equal the latched index in every non-IDLE state.
REQ-019 Hit SHALL be valid[index] and (tag[index] == latched tag), evaluated in COMPARE.
REQ-020 COMPARE, load hit: cpu_ready_o=1 and cpu_rdata_o=lane_rdata_i that cycle; next state IDLE. Load latency from accept to ready is 1 cycle.
REQ-021 COMPARE, load miss: next state FILL.
REQ-022 COMPARE, store: on hit, lane_we_o=latched be and lane_wdata_o=latched wdata for exactly this one cycle; on miss, lane_we_o=0 (no write-allocate). Next state WRITE_MEM in both cases.
REQ-023 FILL: mem_req_o=1, mem_we_o=0, mem_addr_o={latched addr[31:2],2'b00}, held until mem_ack_i=1.
REQ-024 On the FILL ack cycle, SHALL set lane_we_o=4'b1111 and lane_wdata_o=mem_rdata_i, set tag[index]=latched tag and valid[index]=1, capture mem_rdata_i, and move to RESPOND.
REQ-025 WRITE_MEM: mem_req_o=1, mem_we_o=1, mem_wdata_o=latched wdata, mem_be_o=latched be, held until mem_ack_i=1; then move to RESPOND. This is write-through.
REQ-026 RESPOND: cpu_ready_o=1 for one cycle; cpu_rdata_o=captured fill data for loads, 0 for stores; next state IDLE.
REQ-027 mem_ack_i SHALL be accepted in the same cycle mem_req_o first rises, and ignored whenever mem_req_o=0.
REQ-028 Memory port outputs SHALL hold stable while mem_req_o=1 and mem_ack_i=0.
REQ-029 A store with be=0 SHALL perform no lane write and SHALL still issue the memory write with mem_be_o=0.
REQ-030 Loads SHALL ignore cpu_be_i and return the full word.
REQ-031 Outside the cycles named in REQ-022 and REQ-024, lane_we_o SHALL be 0.

Reset
REQ-032 On rst_i=1 at any state, including mid-FILL or mid-WRITE_MEM, the next state SHALL be IDLE and all valid bits SHALL be cleared.
REQ-033 During reset: cpu_busy_o, cpu_ready_o, mem_req_o, mem_we_o and lane_we_o SHALL be 0, and cpu_rdata_o, mem_addr_o, mem_wdata_o and mem_be_o SHALL be 0.
REQ-034 Tag and lane contents need no reset.

Verification
REQ-035 Cold load addr 0x0000_0024, mem returns 0xDEADBEEF after a 3-cycle ack delay -> lane_we_o=1111 at index 1, then ready with rdata 0xDEADBEEF; a repeat load is ready 1 cycle after accept with no mem_req_o.
REQ-036 Store 0x0000_0024, be=0010, wdata 0x0000AB00 after the fill -> lane_we_o=0010 for one cycle, mem write with be=0010; a following load returns 0xDEADABEF.
REQ-037 Store to uncached 0x0000_0048 -> no lane write, mem write issued; a following load of 0x0000_0048 misses (FILL entered).
REQ-038 Conflict: load 0x0000_0024, then load 0x0000_0044 (same index 1, different tag) -> second load misses, and reloading 0x0000_0024 misses again.
REQ-039 rst_i pulsed during FILL before ack -> mem_req_o=0 the next cycle, FSM in IDLE, and a following load of the same address misses.
REQ-040 inv_i=1 together with cpu_req_i=1 in IDLE -> request not accepted (cpu_busy_o stays 0), all lines invalid, and every subsequent load misses.
